adc_serial_responder: RTL

ADC_SERIAL_RESPONDER -- requirements
Module: adc_serial_responder

---
 rtl/adc_serial_responder.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_serial_responder.sv
// Serial responder for an ADC reader: streams a null bit then the sample MSB-first on ADC_clk falls.
// Optional macro ADC_RESP_LSB_TRAILER_EN appends D1..D7 LSB-first after D0 (ADC0832-style frame).
module adc_serial_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ADC_clk,
    input  logic              CS,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              DATA_Out,
    output logic              DATA_OE,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              underrun
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        NULL_BIT,
        SHIFT,
        TRAILER,
        DONE
    } state_t;

    logic [SYNC_STAGES-1:0] adc_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   adc_prev_q;
    logic                   cs_prev_q;
    logic [SYNC_STAGES:0]   flush_q;
    logic                   cs_armed_q;

    logic adc_s, cs_s;
    logic adc_fall, cs_fall, cs_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_sync_q <= '0;
            cs_sync_q  <= '1;
            adc_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            flush_q    <= '0;
            cs_armed_q <= 1'b0;
        end else begin
            adc_sync_q[0] <= ADC_clk;
            cs_sync_q[0]  <= CS;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                adc_sync_q[i] <= adc_sync_q[i-1];
                cs_sync_q[i]  <= cs_sync_q[i-1];
            end
            adc_prev_q <= adc_s;
            cs_prev_q  <= cs_s;
            flush_q    <= {flush_q[SYNC_STAGES-1:0], 1'b1};
            // A CS fall only counts once CS has really been seen high after reset,
            // so a reader still holding CS low across reset cannot start a frame.
            if (flush_q[SYNC_STAGES] && cs_s)
                cs_armed_q <= 1'b1;
        end
    end

    assign adc_s    = adc_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign adc_fall = adc_prev_q & ~adc_s;
    assign cs_fall  = cs_armed_q & cs_prev_q & ~cs_s;
    assign cs_rise  = ~cs_prev_q & cs_s;

    state_t              state_q;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   last_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                data_out_q;
    logic                data_oe_q;
    logic                frame_done_q;
    logic                frame_abort_q;
    logic                underrun_q;

    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                transfer;
    logic                consume;
    logic [DATA_W-1:0]   load_val;

    assign sample_ready = ~hold_full_q;
    assign transfer     = sample_valid & sample_ready;
    assign consume      = (state_q == IDLE) & cs_fall & ~cs_rise;

    // A transfer landing in the same cycle as the frame start bypasses the holding register.
    always_comb begin
        load_val = last_q;
        if (hold_full_q)
            load_val = hold_q;
        else if (transfer)
            load_val = sample_in;
    end

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (consume) begin
            hold_full_d = 1'b0;
        end else if (transfer) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            last_q        <= '0;
            cnt_q         <= '0;
            data_out_q    <= 1'b0;
            data_oe_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            underrun_q    <= 1'b0;
            if (cs_rise) begin
                state_q    <= IDLE;
                data_oe_q  <= 1'b0;
                data_out_q <= 1'b0;
                if (state_q inside {ARMED, NULL_BIT, SHIFT, TRAILER})
                    frame_abort_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        data_oe_q  <= 1'b0;
                        data_out_q <= 1'b0;
                        if (cs_fall) begin
                            state_q <= ARMED;
                            shift_q <= load_val;
                            last_q  <= load_val;
                            if (!hold_full_q && !transfer)
                                underrun_q <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (adc_fall) begin
                            state_q    <= NULL_BIT;
                            data_oe_q  <= 1'b1;
                            data_out_q <= 1'b0;
                        end
                    end
                    NULL_BIT: begin
                        if (adc_fall) begin
                            state_q    <= SHIFT;
                            cnt_q      <= CNT_MAX;
                            data_out_q <= shift_q[DATA_W-1];
                        end
                    end
                    SHIFT: begin
                        if (adc_fall) begin
                            if (cnt_q != '0) begin
                                cnt_q      <= cnt_q - CNT_ONE;
                                data_out_q <= shift_q[cnt_q - CNT_ONE];
                            end else begin
`ifdef ADC_RESP_LSB_TRAILER_EN
                                state_q    <= TRAILER;
                                cnt_q      <= CNT_ONE;
                                data_out_q <= shift_q[1];
`else
                                state_q      <= DONE;
                                data_out_q   <= 1'b0;
                                frame_done_q <= 1'b1;
`endif
                            end
                        end
                    end
                    TRAILER: begin
                        if (adc_fall) begin
                            if (cnt_q == CNT_MAX) begin
                                state_q      <= DONE;
                                data_out_q   <= 1'b0;
                                frame_done_q <= 1'b1;
                            end else begin
                                cnt_q      <= cnt_q + CNT_ONE;
                                data_out_q <= shift_q[cnt_q + CNT_ONE];
                            end
                        end
                    end
                    DONE: begin
                        data_oe_q  <= 1'b1;
                        data_out_q <= 1'b0;
                    end
                    default: begin
                        state_q    <= IDLE;
                        data_oe_q  <= 1'b0;
                        data_out_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DATA_Out    = data_out_q;
    assign DATA_OE     = data_oe_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign underrun    = underrun_q;

endmodule
